// File: rtl/slr_seq.sv
// Multi-cycle logical-right-shift sequencer: shifts by at most STEP bits per clock.
// Optional sticky (OR of all shifted-out bits) output enabled by SLR_SEQ_STICKY_EN.
module slr_seq #(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 1,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    input  logic               flush,
    output logic               busy
`ifdef SLR_SEQ_STICKY_EN
    ,
    output logic               sticky
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] STEP_K = SHAMT_W'(STEP);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] step_k;
    logic [SHAMT_W-1:0] rem_next;
    logic               accept;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

    // flush wins over a same-cycle request, so it also gates the accept.
    assign accept   = in_valid && in_ready && !flush;
    assign step_k   = (rem_q < STEP_K) ? rem_q : STEP_K;
    assign rem_next = rem_q - step_k;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (in_shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
    end

    // NOTE: the data register is reset too, so out_data is never X once reset has been seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            rem_q  <= '0;
        end else if (flush) begin
            rem_q  <= '0;
        end else if (accept) begin
            data_q <= in_data;
            rem_q  <= in_shamt;
        end else if (state_q == SHIFT) begin
            data_q <= data_q >> step_k;
            rem_q  <= rem_next;
        end
    end

`ifdef SLR_SEQ_STICKY_EN
    logic             sticky_q;
    logic [WIDTH-1:0] lost_mask;

    // Low step_k bits of the data register are the ones about to fall off.
    assign lost_mask = ~({WIDTH{1'b1}} << step_k);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (flush || accept) begin
            sticky_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            sticky_q <= sticky_q | (|(data_q & lost_mask));
        end
    end

    assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_slr_seq.sv
// Directed bench for slr_seq: a STEP=1 and a STEP=4 instance driven by shared stimulus.
// Sticky checks are compiled in only when SLR_SEQ_STICKY_EN is defined.
module tb_slr_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        out_ready;
    logic        flush;

    logic        ir1, ov1, busy1;
    logic [31:0] od1;
    logic        ir4, ov4, busy4;
    logic [31:0] od4;
`ifdef SLR_SEQ_STICKY_EN
    logic        stk1_w, stk4_w;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slr_seq #(.WIDTH(32), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .flush(flush), .busy(busy1)
`ifdef SLR_SEQ_STICKY_EN
        , .sticky(stk1_w)
`endif
    );

    slr_seq #(.WIDTH(32), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(ir4), .in_data(in_data), .in_shamt(in_shamt),
        .out_valid(ov4), .out_ready(out_ready), .out_data(od4),
        .flush(flush), .busy(busy4)
`ifdef SLR_SEQ_STICKY_EN
        , .sticky(stk4_w)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp;
        int          lat1;
        int          lat4;
        logic        stk1;
        logic        stk4;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request (both units idle) and records when/what each unit delivers.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [31:0] exp,
                          input int l1, input int l4, input logic k1, input logic k4,
                          input string tag);
        int          n;
        int          got1;
        int          got4;
        logic [31:0] d1;
        logic [31:0] d4;
        logic        st1;
        logic        st4;
        d1 = '0; d4 = '0; st1 = 1'b0; st4 = 1'b0;
        got1 = 0; got4 = 0;
        in_data = d; in_shamt = s; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while ((got1 == 0 || got4 == 0) && n < 40) begin
            if (got1 == 0 && ov1) begin
                got1 = n; d1 = od1;
`ifdef SLR_SEQ_STICKY_EN
                st1 = stk1_w;
`endif
            end
            if (got4 == 0 && ov4) begin
                got4 = n; d4 = od4;
`ifdef SLR_SEQ_STICKY_EN
                st4 = stk4_w;
`endif
            end
            if (got1 == 0 || got4 == 0) begin
                tick();
                n++;
            end
        end
        check({tag, " data step1"}, d1, exp);
        check({tag, " lat step1"}, got1, l1);
        check({tag, " data step4"}, d4, exp);
        check({tag, " lat step4"}, got4, l4);
`ifdef SLR_SEQ_STICKY_EN
        check({tag, " sticky step1"}, {31'd0, st1}, {31'd0, k1});
        check({tag, " sticky step4"}, {31'd0, st4}, {31'd0, k4});
`else
        st1 = k1;
        st4 = k4;
`endif
        tick();
        check({tag, " idle after"}, {30'd0, ir1, ir4}, 32'd3);
    endtask

    initial begin
        int n;
        vecs[0] = '{32'hF000_000F, 5'd4,  32'h0F00_0000, 5,  2, 1'b1, 1'b1};
        vecs[1] = '{32'h8000_0000, 5'd9,  32'h0040_0000, 10, 4, 1'b0, 1'b0};
        vecs[2] = '{32'h1234_5678, 5'd0,  32'h1234_5678, 1,  1, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 32, 9, 1'b1, 1'b1};
        vecs[4] = '{32'h0000_0002, 5'd1,  32'h0000_0001, 2,  2, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0003, 5'd1,  32'h0000_0001, 2,  2, 1'b1, 1'b1};
        vecs[6] = '{32'hA5A5_A5A5, 5'd16, 32'h0000_A5A5, 17, 5, 1'b1, 1'b1};
        vecs[7] = '{32'h8000_0000, 5'd31, 32'h0000_0001, 32, 9, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0100, 5'd8,  32'h0000_0001, 9,  3, 1'b0, 1'b0};
        vecs[9] = '{32'h0000_0100, 5'd9,  32'h0000_0000, 10, 4, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0;
        out_ready = 1'b1; flush = 1'b0;
        tick();
        tick();
        check("reset step1 ready/valid/busy", {29'd0, ir1, ov1, busy1}, 32'h4);
        check("reset step1 out_data", od1, 32'h0);
        check("reset step4 ready/valid/busy", {29'd0, ir4, ov4, busy4}, 32'h4);
        check("reset step4 out_data", od4, 32'h0);
`ifdef SLR_SEQ_STICKY_EN
        check("reset sticky", {30'd0, stk1_w, stk4_w}, 32'h0);
`endif
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].data, vecs[i].shamt, vecs[i].exp, vecs[i].lat1, vecs[i].lat4,
                   vecs[i].stk1, vecs[i].stk4, $sformatf("vec%0d", i));
        end

        // shamt=0: result next cycle, no new accept until after the output handshake.
        in_data = 32'h1234_5678; in_shamt = 5'd0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("zero shamt out_valid", {31'd0, ov1}, 32'd1);
        check("zero shamt in_ready low", {31'd0, ir1}, 32'd0);
        check("zero shamt data", od1, 32'h1234_5678);
        in_valid = 1'b0;
        tick();
        check("zero shamt ready again", {30'd0, ir1, ov1}, 32'd2);
        tick();

        // Backpressure: result must hold while out_ready is low.
        in_data = 32'hFFFF_FFFF; in_shamt = 5'd31; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!ov1 && n < 40) begin
            tick();
            n++;
        end
        check("backpressure reached done", {31'd0, ov1}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("backpressure hold data", od1, 32'h0000_0001);
            check("backpressure hold flags", {29'd0, ov1, ir1, ov4}, 32'h5);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("backpressure release idle", {28'd0, ir1, busy1, ir4, busy4}, 32'hA);

        // Flush during the second SHIFT cycle.
        in_data = 32'hFFFF_FFFF; in_shamt = 5'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("flush pre busy", {30'd0, busy1, ov1}, 32'd2);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush step1 idle", {29'd0, ir1, busy1, ov1}, 32'h4);
        check("flush step4 idle", {29'd0, ir4, busy4, ov4}, 32'h4);
        for (int i = 0; i < 5; i++) begin
            check("flush no output", {30'd0, ov1, ov4}, 32'd0);
            tick();
        end
        run_op(32'h0000_0002, 5'd1, 32'h0000_0001, 2, 2, 1'b0, 1'b0, "post flush");

        // flush in IDLE with a request pending must not accept it.
        in_data = 32'h0000_00FF; in_shamt = 5'd3; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        check("flush blocks accept", {30'd0, busy1, busy4}, 32'd0);

        // Reset for one edge mid-SHIFT.
        in_data = 32'hDEAD_BEEF; in_shamt = 5'd20; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid reset flags", {26'd0, ir1, ov1, busy1, ir4, ov4, busy4}, 32'h24);
        check("mid reset step1 data", od1, 32'h0);
        check("mid reset step4 data", od4, 32'h0);
`ifdef SLR_SEQ_STICKY_EN
        check("mid reset sticky", {30'd0, stk1_w, stk4_w}, 32'h0);
`endif
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid reset no output", {30'd0, ov1, ov4}, 32'd0);
        end

        // Reset held while a request is offered: no accept.
        rst_n = 1'b0; in_valid = 1'b1; in_shamt = 5'd2; in_data = 32'h0000_0010;
        tick();
        check("reset blocks accept", {28'd0, ir1, busy1, ir4, busy4}, 32'hA);
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check("after reset still idle", {30'd0, busy1, busy4}, 32'd0);

        run_op(32'h8000_0001, 5'd3, 32'h1000_0000, 4, 2, 1'b1, 1'b1, "final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
